// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - SDRAM command/state encodings and timing defaults shared by the read and write controllers
package sdr_pkg;

  localparam int SDR_NRCD_DEFAULT = 3;
  localparam int SDR_NWR_DEFAULT  = 2;
  localparam int SDR_NRP_DEFAULT  = 3;
  localparam int CNT_W            = 8;

  // {nRAS, nCAS, nWE}
  typedef enum logic [2:0] {
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_NOP       = 3'b111
  } sdr_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_WRITE,
    ST_RECOVER,
    ST_PRECHARGE,
    ST_WAIT_RP
  } sdr_state_e;

  function automatic logic [CNT_W-1:0] dly_val(input int cycles);
    return CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/sdr_dly_cnt.sv
// rtl/sdr_dly_cnt.sv - loadable down-counter with zero flag, shared by the tRCD, tWR and tRP waits
module sdr_dly_cnt
  import sdr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdr_wr.sv
// rtl/sdr_wr.sv - SDRAM single-bank write burst controller with registered pin outputs
// SDR_WR_AUTO_PRECHARGE_EN: close the row with A10 on the last WRITE instead of a PRECHARGE command
module sdr_wr
  import sdr_pkg::*;
#(
  parameter int NRCD = SDR_NRCD_DEFAULT,
  parameter int NWR  = SDR_NWR_DEFAULT,
  parameter int NRP  = SDR_NRP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [1:0]  wr_bank_addr,
  input  logic [12:0] wr_row_addr,
  input  logic [8:0]  wr_col_addr,
  input  logic [2:0]  wr_len,
  output logic        wr_data_rdy,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_mask,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        sdr_CKE,
  output logic        sdr_nCS,
  output logic [1:0]  sdr_BA,
  output logic [12:0] sdr_A,
  output logic        sdr_nRAS,
  output logic        sdr_nCAS,
  output logic        sdr_nWE,
  output logic [15:0] sdr_DQ,
  output logic        sdr_DQ_oe,
  output logic [1:0]  sdr_DQM
);

`ifdef SDR_WR_AUTO_PRECHARGE_EN
  localparam bit AUTO_PRE = 1'b1;
`else
  localparam bit AUTO_PRE = 1'b0;
`endif

  sdr_state_e       state_q, state_d;
  logic [1:0]       bank_q, bank_d;
  logic [8:0]       col_q, col_d;
  logic [2:0]       len_q, len_d;
  logic [2:0]       idx_q, idx_d;
  sdr_cmd_e         cmd_q, cmd_d;
  logic [1:0]       ba_q, ba_d;
  logic [12:0]      a_q, a_d;
  logic [15:0]      dq_q, dq_d;
  logic             oe_q, oe_d;
  logic [1:0]       dqm_q, dqm_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             wr_issue, wr_last;

  sdr_dly_cnt u_dly (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .val_i  (cnt_val),
    .cnt_o  (cnt),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    col_d    = col_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cmd_d    = CMD_NOP;
    ba_d     = ba_q;
    a_d      = a_q;
    dq_d     = '0;
    oe_d     = 1'b0;
    dqm_d    = 2'b11;
    rdy_d    = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    wr_issue = 1'b0;
    wr_last  = (idx_q == len_q);
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (wr_req) begin
          bank_d   = wr_bank_addr;
          col_d    = wr_col_addr;
          len_d    = wr_len;
          idx_d    = '0;
          cmd_d    = CMD_ACTIVE;
          ba_d     = wr_bank_addr;
          a_d      = wr_row_addr;
          cnt_load = 1'b1;
          cnt_val  = dly_val(NRCD - 1);
          rdy_d    = (NRCD == 1);
          busy_d   = 1'b1;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Raise the pull strobe one cycle ahead of the first WRITE edge.
        if (cnt_zero) begin
          wr_issue = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          rdy_d   = (cnt == dly_val(1));
        end
      end
      ST_WRITE: wr_issue = 1'b1;
      ST_RECOVER: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (AUTO_PRE) begin
          cnt_load = 1'b1;
          cnt_val  = dly_val(NRP);
          state_d  = ST_WAIT_RP;
        end else begin
          state_d = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        cmd_d    = CMD_PRECHARGE;
        ba_d     = bank_q;
        a_d      = '0;
        cnt_load = 1'b1;
        cnt_val  = dly_val(NRP - 1);
        state_d  = ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wr_issue) begin
      cmd_d = CMD_WRITE;
      ba_d  = bank_q;
      a_d   = {2'b00, (AUTO_PRE && wr_last), 1'b0, col_q + 9'(idx_q)};
      dq_d  = wr_data;
      dqm_d = wr_mask;
      oe_d  = 1'b1;
      idx_d = idx_q + 3'd1;
      if (wr_last) begin
        cnt_load = 1'b1;
        cnt_val  = dly_val(NWR - 1);
        state_d  = ST_RECOVER;
      end else begin
        rdy_d   = 1'b1;
        state_d = ST_WRITE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      col_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      a_q     <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      dqm_q   <= 2'b11;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      col_q   <= col_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      dqm_q   <= dqm_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sdr_CKE                      = 1'b1;
  assign sdr_nCS                      = 1'b0;
  assign {sdr_nRAS, sdr_nCAS, sdr_nWE} = cmd_q;
  assign sdr_BA                       = ba_q;
  assign sdr_A                        = a_q;
  assign sdr_DQ                       = dq_q;
  assign sdr_DQ_oe                    = oe_q;
  assign sdr_DQM                      = dqm_q;
  assign wr_data_rdy                  = rdy_q;
  assign wr_busy                      = busy_q;
  assign wr_done                      = done_q;

endmodule

// File: tb/tb_sdr_wr.sv
// tb/tb_sdr_wr.sv - scoreboard bench for sdr_wr: timing model in absolute cycles, monitor checks pins
module tb_sdr_wr;
  import sdr_pkg::*;

  localparam int NRCD = 3;
  localparam int NWR  = 2;
  localparam int NRP  = 3;
`ifdef SDR_WR_AUTO_PRECHARGE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [1:0]  wr_bank_addr = '0;
  logic [12:0] wr_row_addr = '0;
  logic [8:0]  wr_col_addr = '0;
  logic [2:0]  wr_len = '0;
  logic        wr_data_rdy;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic        wr_busy, wr_done;
  logic        sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_DQ_oe;
  logic [1:0]  sdr_BA, sdr_DQM;
  logic [12:0] sdr_A;
  logic [15:0] sdr_DQ;

  sdr_wr #(.NRCD(NRCD), .NWR(NWR), .NRP(NRP)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_bank_addr(wr_bank_addr),
    .wr_row_addr(wr_row_addr), .wr_col_addr(wr_col_addr), .wr_len(wr_len),
    .wr_data_rdy(wr_data_rdy), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_busy(wr_busy), .wr_done(wr_done), .sdr_CKE(sdr_CKE), .sdr_nCS(sdr_nCS),
    .sdr_BA(sdr_BA), .sdr_A(sdr_A), .sdr_nRAS(sdr_nRAS), .sdr_nCAS(sdr_nCAS),
    .sdr_nWE(sdr_nWE), .sdr_DQ(sdr_DQ), .sdr_DQ_oe(sdr_DQ_oe), .sdr_DQM(sdr_DQM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          t;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [15:0] dq;
    logic [1:0]  dqm;
  } ev_t;

  ev_t         exp_cmd[$];
  int          exp_done[$];
  logic [17:0] wq[$];
  int checks = 0, errors = 0;
  int busy_from = 1, busy_until = 0;
  int rdy_seen = 0, rdy_exp = 0;
  bit rst_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, cyc + 1, act, exp);
    end
  endtask

  task automatic flag(input string name, input int got, input int exp);
    checks++;
    errors++;
    $display("FAIL %s at t=%0d: got %0d expected %0d", name, cyc + 1, got, exp);
  endtask

  // Times are the clock edge at which the SDRAM samples the pins.
  int         lbl;
  logic [2:0] cmd;
  ev_t        ev;
  int         dt;
  always @(negedge clk) begin
    lbl = cyc + 1;
    cmd = {sdr_nRAS, sdr_nCAS, sdr_nWE};
    if (rst_chk) begin
      rst_chk = 1'b0;
      chk("rst_cmd", 32'(cmd), 32'(CMD_NOP));
      chk("rst_ba", 32'(sdr_BA), 0);
      chk("rst_a", 32'(sdr_A), 0);
      chk("rst_dq", 32'(sdr_DQ), 0);
      chk("rst_rdy", 32'(wr_data_rdy), 0);
      chk("rst_done", 32'(wr_done), 0);
      chk("rst_cke_cs", 32'({sdr_CKE, sdr_nCS}), 32'b10);
    end
    while (exp_cmd.size() > 0 && exp_cmd[0].t < lbl) begin
      ev = exp_cmd.pop_front();
      flag("cmd_missing_at", lbl, ev.t);
    end
    while (exp_done.size() > 0 && exp_done[0] < lbl) begin
      dt = exp_done.pop_front();
      flag("done_missing_at", lbl, dt);
    end
    if (cmd != 3'(CMD_NOP)) begin
      if (exp_cmd.size() > 0 && exp_cmd[0].t == lbl) begin
        ev = exp_cmd.pop_front();
        chk("cmd", 32'(cmd), 32'(ev.cmd));
        chk("ba", 32'(sdr_BA), 32'(ev.ba));
        if (ev.cmd == 3'(CMD_PRECHARGE)) begin
          chk("pre_a10", 32'(sdr_A[10]), 0);
        end else begin
          chk("addr", 32'(sdr_A), 32'(ev.a));
        end
        if (ev.cmd == 3'(CMD_WRITE)) begin
          chk("dq", 32'(sdr_DQ), 32'(ev.dq));
          chk("dqm", 32'(sdr_DQM), 32'(ev.dqm));
          chk("oe", 32'(sdr_DQ_oe), 1);
        end
      end else begin
        flag("cmd_unexpected", int'(cmd), 7);
      end
    end
    if (cmd != 3'(CMD_WRITE)) begin
      chk("idle_oe_dqm", 32'({sdr_DQ_oe, sdr_DQM}), 32'b011);
    end
    if (wr_done) begin
      if (exp_done.size() > 0 && exp_done[0] == lbl) begin
        dt = exp_done.pop_front();
        chk("done", 32'(wr_done), 1);
      end else begin
        flag("done_unexpected", lbl, -1);
      end
    end
    chk("busy", 32'(wr_busy), 32'(lbl >= busy_from && lbl <= busy_until));
    if (wr_data_rdy) rdy_seen++;
  end

  // One cycle of stimulus; called just after a falling edge, drives inputs for the next rising edge T.
  task automatic step(input bit req, input bit do_rst, input logic [1:0] b, input logic [12:0] r,
                      input logic [8:0] c, input logic [2:0] l,
                      input logic [7:0][15:0] wv, input logic [7:0][1:0] mv);
    int T, first, w, d;
    logic [8:0] col;
    T = cyc + 1;
    if (wr_data_rdy) begin
      if (wq.size() > 0) {wr_mask, wr_data} = wq.pop_front();
      else flag("rdy_extra", 1, 0);
    end else begin
      wr_data = 16'($urandom);
      wr_mask = 2'($urandom);
    end
    rst = do_rst;
    wr_req = req;
    wr_bank_addr = b;
    wr_row_addr = r;
    wr_col_addr = c;
    wr_len = l;
    if (do_rst) begin
      exp_cmd.delete();
      exp_done.delete();
      wq.delete();
      busy_until = T;
      busy_from = T + 1;
      rdy_seen = 0;
      rdy_exp = 0;
      rst_chk = 1'b1;
    end else if (req && T >= busy_until) begin
      exp_cmd.push_back('{T + 1, 3'(CMD_ACTIVE), b, r, 16'h0, 2'b11});
      first = T + 1 + NRCD;
      for (int i = 0; i <= int'(l); i++) begin
        col = c + 9'(i);
        exp_cmd.push_back('{first + i, 3'(CMD_WRITE), b,
                            {2'b00, (AUTO && i == int'(l)), 1'b0, col}, wv[i], mv[i]});
        wq.push_back({mv[i], wv[i]});
      end
      w = first + int'(l);
      if (!AUTO) exp_cmd.push_back('{w + NWR + 1, 3'(CMD_PRECHARGE), b, 13'h0, 16'h0, 2'b11});
      d = w + NWR + 1 + NRP;
      exp_done.push_back(d);
      busy_from = T + 1;
      busy_until = d;
      rdy_exp += int'(l) + 1;
    end
    @(negedge clk);
    #1;
  endtask

  logic [7:0][15:0] wv;
  logic [7:0][1:0]  mv;

  task automatic rnd_words();
    for (int i = 0; i < 8; i++) begin
      wv[i] = 16'($urandom);
      mv[i] = (($urandom_range(0, 3)) == 0) ? 2'($urandom) : 2'b00;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 2'($urandom), 13'($urandom), 9'($urandom), 3'($urandom), wv, mv);
    end
  endtask

  int rdy_mark;
  initial begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, '0, '0, '0, wv, mv);

    wv = '0; mv = '0;
    wv[0] = 16'hA5A5;
    step(1'b1, 1'b0, 2'd2, 13'h1ABC, 9'h005, 3'd0, wv, mv);
    idle(14);

    for (int i = 0; i < 8; i++) wv[i] = 16'(i + 1);
    rdy_mark = rdy_seen;
    step(1'b1, 1'b0, 2'd1, 13'h0042, 9'h1FC, 3'd7, wv, mv);
    idle(25);
    chk("rdy_len8", 32'(rdy_seen - rdy_mark), 8);

    mv = '0;
    mv[2] = 2'b10;
    rnd_words();
    mv = '0;
    mv[2] = 2'b10;
    step(1'b1, 1'b0, 2'd3, 13'h0F0F, 9'h010, 3'd3, wv, mv);
    idle(20);

    rnd_words();
    step(1'b1, 1'b0, 2'd0, 13'h1234, 9'h100, 3'd7, wv, mv);
    idle(NRCD + 1);
    step(1'b0, 1'b1, '0, '0, '0, '0, wv, mv);
    wv = '0; mv = '0;
    wv[0] = 16'hA5A5;
    step(1'b1, 1'b0, 2'd2, 13'h1ABC, 9'h005, 3'd0, wv, mv);
    idle(15);

    for (int i = 0; i < 80; i++) begin
      rnd_words();
      step(1'b1, 1'b0, 2'($urandom), 13'($urandom), 9'($urandom), 3'($urandom), wv, mv);
    end

    for (int i = 0; i < 900; i++) begin
      rnd_words();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0),
           2'($urandom), 13'($urandom), 9'($urandom), 3'($urandom), wv, mv);
    end

    idle(40);
    chk("cmd_queue_drained", 32'(exp_cmd.size()), 0);
    chk("done_queue_drained", 32'(exp_done.size()), 0);
    chk("data_queue_drained", 32'(wq.size()), 0);
    chk("rdy_count", 32'(rdy_seen), 32'(rdy_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdr_wr.md
SDR_WR -- requirements
Module: sdr_wr

Interface
REQ-001 Parameter NRCD, 3, ACTIVE-to-WRITE delay in clk cycles (tRCD/tCK).
REQ-002 Parameter NWR, 2, write recovery in clk cycles after the last WRITE command (tWR/tCK).
REQ-003 Parameter NRP, 3, PRECHARGE-to-idle delay in clk cycles (tRP/tCK).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 wr_req  input  1  start a write burst; sampled only while idle.
REQ-007 wr_bank_addr  input  2  target bank.
REQ-008 wr_row_addr  input  13  target row.
REQ-009 wr_col_addr  input  9  start column.
REQ-010 wr_len  input  3  burst length minus one (0 = 1 word, 7 = 8 words).
REQ-011 wr_data_rdy  output  1  pull strobe; the user presents wr_data/wr_mask in this same cycle.
REQ-012 wr_data  input  16  write word.
REQ-013 wr_mask  input  2  byte mask driven onto sdr_DQM with the word (1 = masked).
REQ-014 wr_busy  output  1  burst in progress.
REQ-015 wr_done  output  1  one-cycle completion pulse.
REQ-016 SDRAM pins: sdr_CKE out 1, sdr_nCS out 1, sdr_BA out 2, sdr_A out 13, sdr_nRAS/sdr_nCAS/sdr_nWE out 1 each, sdr_DQ out 16, sdr_DQ_oe out 1 (tristate enable), sdr_DQM out 2.

Function
REQ-017 States: IDLE, ACTIVE, WRITE, RECOVER, PRECHARGE, WAIT_RP; all pin outputs are registered.
REQ-018 IDLE: wr_req at edge T latches bank, row, col and len, and drives the ACTIVE command (BA = bank, A = row) from edge T+1.
REQ-019 The first WRITE command appears at T+1+NRCD; each following word issues one WRITE command per cycle, with no gaps.
REQ-020 wr_data_rdy is high in the cycle before each WRITE command, so the count equals wr_len+1; wr_data and wr_mask are registered onto sdr_DQ and sdr_DQM with that command, and sdr_DQ_oe=1.
REQ-021 WRITE column = start col + word index, modulo 512 (wraps 0x1FF->0x000); A[12:11]=0, A[10]=0 except as in REQ-032, A[9]=0.
REQ-022 Every cycle that is not a WRITE drives NOP (111), sdr_DQ_oe=0 and sdr_DQM=2'b11.
REQ-023 With the last WRITE issued at W: RECOVER for NWR cycles; PRECHARGE command (A10=0, BA = latched bank) at W+NWR+1.
REQ-024 With PRECHARGE issued at P: wr_done pulses at P+NRP; IDLE is re-entered at the same edge.
REQ-025 wr_busy is high from T+1 through the wr_done cycle inclusive; a new wr_req is accepted in the cycle after wr_done.
REQ-026 wr_req while busy is ignored; address and length changes while busy are ignored.
REQ-027 sdr_CKE is constant 1 and sdr_nCS is constant 0.
REQ-028 Command encodings {nRAS,nCAS,nWE}: NOP 111, ACTIVE 011, WRITE 100, PRECHARGE 010.

Reset
REQ-029 rst=1 at any edge, including mid-burst, forces IDLE and clears all counters; at that edge: NOP, BA=0, A=0, DQ=0, DQ_oe=0, DQM=2'b11, wr_data_rdy=0, wr_busy=0, wr_done=0.
REQ-030 An aborted burst produces no wr_done pulse; the first wr_req after rst deasserts is accepted normally.

Configuration
REQ-031 Macro SDR_WR_AUTO_PRECHARGE_EN selects the precharge scheme.
REQ-032 Defined: the last WRITE carries A10=1, the PRECHARGE state is skipped, and wr_done pulses at W+NWR+1+NRP. Undefined: explicit PRECHARGE per REQ-023/024.

Structure
REQ-033 Shared package sdr_pkg holds the command encodings, the state encoding, and the defaults for NRCD, NWR and NRP (shared with the read controller).
REQ-034 One sub-module, sdr_dly_cnt: a loadable down-counter with a zero flag, reused for the tRCD, tWR and tRP waits.

Verification
REQ-035 NRCD=3, NWR=2, NRP=3; wr_req at T, bank 2, row 0x1ABC, col 0x005, len 0, data 0xA5A5 -> ACTIVE at T+1 (BA=2, A=0x1ABC); WRITE at T+4 (A=0x005, DQ=0xA5A5, oe=1); PRECHARGE at T+7; wr_done at T+10.
REQ-036 len 7, col 0x1FC, data 0x0001..0x0008 -> eight consecutive WRITEs at columns 0x1FC..0x1FF, 0x000..0x003 with matching data; wr_data_rdy high for exactly 8 cycles.
REQ-037 wr_mask=2'b10 on word 2 of a 4-word burst -> sdr_DQM=2'b10 only on the third WRITE, 2'b00 on the other WRITEs, 2'b11 on all non-WRITE cycles.
REQ-038 wr_req held high through a burst and wr_req pulses mid-burst -> exactly one ACTIVE per accepted burst; next ACTIVE occurs 1 cycle after wr_done.
REQ-039 rst pulsed during the 3rd WRITE of an 8-word burst -> NOP with oe=0 at that edge, no wr_done; a following single-word request completes per REQ-035 timing.
REQ-040 Build with SDR_WR_AUTO_PRECHARGE_EN, same stimulus as REQ-035 -> WRITE at T+4 with A=0x405, no PRECHARGE command, wr_done at T+10.
